req_ack_responder: RTL and testbench
====================================

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 Parameter data_width, default 32: width of the data word.
REQ-002 Parameter depth, default 4: number of buffer entries; SHALL be a power of two, 2 or greater.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream word is present on in_data.
REQ-006 Port in_ready, output, 1: buffer can accept a word this cycle.
REQ-007 Port in_data, input, data_width: upstream word.
REQ-008 Port req, input, 1: level request from the downstream requester.
REQ-009 Port ack, output, 1: one-cycle acknowledge; dout is valid while ack=1.
REQ-010 Port dout, output, data_width: delivered word (registered).
REQ-011 Port count, output, 32: total acks issued.
REQ-012 Port level, output, log2(depth)+1: current occupancy.

Function
REQ-013 The block SHALL be the responder end of the req/ack protocol: the downstream side raises and holds req; this block answers with an ack pulse carrying data.
REQ-014 The block SHALL buffer words in a circular FIFO of depth entries, with a read pointer, a write pointer and an occupancy counter.
REQ-015 in_ready SHALL equal (level != depth), decoded combinationally from registered state.
REQ-016 A push SHALL occur at an edge where in_valid & in_ready: write in_data at the write pointer, increment the write pointer modulo depth.
REQ-017 A pop SHALL occur at an edge where req & ~ack & (level != 0).
REQ-018 On a pop, at the same edge: ack<=1, dout<=entry at read pointer, read pointer increments modulo depth, count<=count+1.
REQ-019 At every edge without a pop, ack SHALL return to 0, so ack is never high two cycles in a row and the maximum rate is one word per two cycles.
REQ-020 dout SHALL hold its last delivered value when no pop occurs.
REQ-021 level SHALL update as: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 Empty-bypass is forbidden: a word pushed at edge N SHALL become poppable no earlier than edge N+1.
REQ-023 When full, in_ready=0; a pop at edge N SHALL raise in_ready after edge N.
REQ-024 A push and a pop at the same edge SHALL both complete, with each pointer advancing independently.
REQ-025 Pointer wrap from depth-1 to 0 SHALL preserve FIFO order.
REQ-026 count SHALL wrap modulo 2^32.
REQ-027 req deasserted while ack=1 SHALL have no effect on the delivered word.
REQ-028 req held high after ack SHALL cause a new pop on the following edge, provided data is present.
REQ-029 req with level=0 SHALL cause no ack and no state change; the ack SHALL issue at the first edge where level!=0 and req is still high.

Reset
REQ-030 While rst=1, immediately and independently of clk: ack=0, dout=0, count=0, level=0, both pointers=0, hence in_ready=1.
REQ-031 Buffer contents SHALL need no reset; they are unreachable after pointer reset.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered words; a pending req SHALL be ignored until rst falls and data arrives.

Verification
REQ-033 Fill/order: depth=4; push 10,11,12,13 with req=0. Expect in_ready=0 and level=4. Then hold req=1: expect acks on alternate cycles with dout 10,11,12,13, and count=4.
REQ-034 Empty request: hold req=1 with no data for 5 cycles, expecting no ack. Push 7 at edge N: expect ack=1 and dout=7 after edge N+1, not earlier.
REQ-035 Simultaneous: level=2, in_valid=1 and req=1 at the same edge. Expect level still 2, one ack, and the pushed word delivered after the older ones.
REQ-036 Wrap: stream 0..99 through with a random in_valid and a consumer-style req. The output sequence must be exactly 0..99, with count=100 and no back-to-back ack.
REQ-037 Async reset: level=3, assert rst between clock edges. Expect ack, dout, count and level at 0 without waiting for a clock edge. After release with req=1 and no data, expect no ack.
REQ-038 Full backpressure: with level=4, hold in_valid=1 with value 99. Expect no push until the first pop; 99 is then accepted at the next edge and delivered last.

Source files
------------

// File: rtl/req_ack_responder.sv
// Responder end of a req/ack handshake: words are buffered in a circular FIFO
// and handed out one per ack pulse, at most one word every two cycles.
module req_ack_responder #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   in_data,
    input  logic                    req,
    output logic                    ack,
    output logic [data_width-1:0]   dout,
    output logic [31:0]             count,
    output logic [$clog2(depth):0]  level
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(depth);

    logic [data_width-1:0] mem_q [depth];

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         level_q,  level_d;
    logic                  ack_q,    ack_d;
    logic [data_width-1:0] dout_q,   dout_d;
    logic [31:0]           count_q,  count_d;
    logic                  push, pop;

    assign in_ready = (level_q != FULL_LEVEL);
    assign ack      = ack_q;
    assign dout     = dout_q;
    assign count    = count_q;
    assign level    = level_q;

    // Pop decision uses registered level only, so a word written this edge
    // cannot be delivered before the next one.
    always_comb begin
        push     = in_valid & in_ready;
        pop      = req & ~ack_q & (level_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ack_d    = 1'b0;
        dout_d   = dout_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            ack_d    = 1'b1;
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            dout_q   <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            count_q  <= count_d;
        end
    end

    // Storage is unreachable after a pointer reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboarded bench for req_ack_responder: accepted words are queued and
// matched against dout on every ack, alongside a small occupancy/ack model.
module tb_req_ack_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          req = 1'b0;
    logic          ack;
    logic [DW-1:0] dout;
    logic [31:0]   count;
    logic [LW-1:0] level;

    req_ack_responder #(
        .data_width (DW),
        .depth      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req      (req),
        .ack      (ack),
        .dout     (dout),
        .count    (count),
        .level    (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the spec: occupancy, ack and ack counter.
    logic [DW-1:0] exp_q[$];
    int unsigned   m_level = 0;
    logic          m_ack = 1'b0;
    logic [31:0]   m_count = '0;
    logic [DW-1:0] m_dout = '0;
    int unsigned   n_pushed = 0;
    int unsigned   ack_seen = 0;
    logic          prev_ack = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_level = 0;
            m_ack   = 1'b0;
            m_count = '0;
            m_dout  = '0;
            exp_q.delete();
        end else begin
            automatic bit p = in_valid && (m_level != DEPTH);
            automatic bit q = req && !m_ack && (m_level != 0);
            if (p) begin
                exp_q.push_back(in_data);
                n_pushed++;
            end
            m_ack = q;
            if (q) m_count = m_count + 32'd1;
            if (p && !q) m_level = m_level + 1;
            if (q && !p) m_level = m_level - 1;
        end
    end

    always @(negedge clk) begin
        check("ack", ack, m_ack);
        check("level", level, m_level);
        check("count", count, m_count);
        check("in_ready", in_ready, m_level != DEPTH);
        check("ack_b2b", ack & prev_ack, 0);
        if (ack) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", ack, 0);
            end else begin
                m_dout = exp_q.pop_front();
            end
        end
        check("dout", dout, m_dout);
        prev_ack = ack;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(input int unsigned n, input int unsigned budget);
        automatic int unsigned target = ack_seen + n;
        for (int unsigned c = 0; c < budget && ack_seen < target; c++) tick();
        check("ack_timeout", ack_seen >= target, 1);
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_ack", ack, 0);
        check("rst_dout", dout, 0);
        check("rst_count", count, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Fill and drain in order
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_level", level, 4);
        check("fill_in_ready", in_ready, 0);
        req = 1'b1;
        wait_acks(4, 20);
        req = 1'b0;
        check("fill_count", count, 4);
        tick();

        // Request on empty buffer, then a late push
        req = 1'b1;
        repeat (5) tick();
        in_valid = 1'b1;
        in_data  = DW'(7);
        tick();
        in_valid = 1'b0;
        check("nobypass_ack", ack, 0);
        tick();
        check("late_ack", ack, 1);
        check("late_dout", dout, 7);
        req = 1'b0;
        tick();

        // Simultaneous push and pop at level 2
        in_valid = 1'b1;
        in_data = DW'(20); tick();
        in_data = DW'(21); tick();
        in_valid = 1'b0;
        check("sim_pre_level", level, 2);
        in_valid = 1'b1;
        in_data  = DW'(22);
        req      = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sim_level", level, 2);
        check("sim_ack", ack, 1);
        check("sim_dout", dout, 20);
        wait_acks(2, 20);
        req = 1'b0;
        tick();

        // Backpressure when full
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(30 + i);
            tick();
        end
        in_data = DW'(99);
        repeat (3) tick();
        check("bp_level", level, 4);
        check("bp_in_ready", in_ready, 0);
        req = 1'b1;
        wait_acks(1, 10);
        tick();
        in_valid = 1'b0;
        check("bp_refill_level", level, 4);
        wait_acks(4, 20);
        check("bp_last_dout", dout, 99);
        req = 1'b0;
        tick();

        // Asynchronous reset mid-cycle
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(40 + i);
            tick();
        end
        in_valid = 1'b0;
        check("ar_pre_level", level, 3);
        req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_ack", ack, 0);
        check("ar_dout", dout, 0);
        check("ar_count", count, 0);
        check("ar_level", level, 0);
        check("ar_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("ar_noack", ack, 0);
        end
        req = 1'b0;
        tick();

        // Streaming 0..99 with random valid and consumer-style req
        begin
            automatic int unsigned push_base = n_pushed;
            automatic int unsigned ack_base  = ack_seen;
            for (int c = 0; c < 3000 && (ack_seen - ack_base) < 100; c++) begin
                automatic int unsigned sent = n_pushed - push_base;
                in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
                in_data  = DW'(sent);
                if (ack) req = ($urandom_range(0, 1) != 0);
                else if (!req) req = ($urandom_range(0, 2) != 0);
                tick();
            end
            in_valid = 1'b0;
            req      = 1'b0;
            check("stream_acks", ack_seen - ack_base, 100);
            check("stream_count", count, 100);
            check("stream_last", dout, 99);
            tick();
            check("sb_empty", exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
